// File: rtl/team_06_i2s_pkg.sv
// Shared defaults and width helpers for the team_06 I2S transmit path.
package team_06_i2s_pkg;

  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_SLOT_W   = 16;
  localparam int DEF_CLK_DIV  = 4;

  // bit_cnt has to span one full frame of two slots
  function automatic int bit_cnt_width(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

endpackage

// File: rtl/team_06_i2s_bclk_gen.sv
// Bit-clock generator: divides clk into i2s_sclk and flags the cycle whose
// closing edge drives i2s_sclk low, so serial state can update on that same edge.
module team_06_i2s_bclk_gen
  import team_06_i2s_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic i2s_sclk,
  output logic fall_evt
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt  <= '0;
      i2s_sclk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      i2s_sclk <= ~i2s_sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign fall_evt = i2s_sclk && (div_cnt == DIV_LAST);

endmodule

// File: rtl/team_06_i2s_tx.sv
// Mono I2S transmitter: one-entry sample buffer feeding an MSB-first serializer
// that repeats each sample in the left and right slots.
module team_06_i2s_tx
  import team_06_i2s_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_sclk,
  output logic                i2s_ws,
  output logic                i2s_sd,
  output logic                underrun
);

  localparam int BW = bit_cnt_width(SLOT_W);
  localparam logic [BW-1:0] CNT_LAST = BW'(2 * SLOT_W - 1);
  localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_W);

  logic                fall_evt;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       next_cnt;
  logic [BW-1:0]       slot_pos;
  logic [SAMPLE_W-1:0] buffer;
  logic [SAMPLE_W-1:0] frame_sample;
  logic [SAMPLE_W-1:0] load_src;
  logic [SAMPLE_W-1:0] shifted;
  logic                buf_full;
  logic                frame_start;
  logic                accept;

  team_06_i2s_bclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_bclk (
    .clk     (clk),
    .rst     (rst),
    .i2s_sclk(i2s_sclk),
    .fall_evt(fall_evt)
  );

  assign sample_ready = !buf_full;
  assign accept       = sample_valid && !buf_full;

  // The current bit_cnt is the slot position of the bit about to be shown,
  // so shifting by it puts that bit in the MSB; positions past the sample shift out to 0.
  always_comb begin
    next_cnt    = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
    slot_pos    = (bit_cnt >= SLOT_LEN) ? bit_cnt - SLOT_LEN : bit_cnt;
    frame_start = (bit_cnt == '0);
    load_src    = frame_start ? (buf_full ? buffer : '0) : frame_sample;
    shifted     = load_src << slot_pos;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt      <= '0;
      frame_sample <= '0;
      buffer       <= '0;
      buf_full     <= 1'b0;
      i2s_ws       <= 1'b0;
      i2s_sd       <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (fall_evt) begin
        bit_cnt <= next_cnt;
        i2s_ws  <= (next_cnt >= SLOT_LEN);
        i2s_sd  <= shifted[SAMPLE_W-1];
        if (frame_start) begin
          frame_sample <= load_src;
          underrun     <= !buf_full;
        end
      end
      // An accept only happens while empty, so it never collides with a load draining the buffer
      if (accept) begin
        buffer   <= sample_in;
        buf_full <= 1'b1;
      end else if (fall_evt && frame_start) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Bench for team_06_i2s_tx: a time-based frame model checked every cycle,
// plus directed scenarios pinned by hand-computed values.
module tb_team_06_i2s_tx;

  localparam int CLK_DIV  = 2;
  localparam int SAMPLE_W = 8;
  localparam int SLOT_W   = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                sample_valid = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_ready;
  logic                i2s_sclk;
  logic                i2s_ws;
  logic                i2s_sd;
  logic                underrun;

  always #5 clk = ~clk;

  team_06_i2s_tx #(
    .CLK_DIV (CLK_DIV),
    .SAMPLE_W(SAMPLE_W),
    .SLOT_W  (SLOT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .i2s_sclk    (i2s_sclk),
    .i2s_ws      (i2s_ws),
    .i2s_sd      (i2s_sd),
    .underrun    (underrun)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model state: t = clk cycles since the last reset edge
  int                  t = 0;
  bit                  m_valid = 1'b0;
  bit                  m_full = 1'b0;
  bit                  m_under = 1'b0;
  logic [SAMPLE_W-1:0] m_buf = '0;
  logic [SAMPLE_W-1:0] m_frame = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic applyStimulus(input logic valid, input logic [SAMPLE_W-1:0] data);
    sample_valid = valid;
    sample_in    = data;
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] b);
    return {1'b0, b, 8'h00, b, 7'h00};
  endfunction

  // Frame loads happen on every bit-clock fall that makes the frame position 1
  always @(posedge clk) begin
    bit accept_now;
    bit load_now;
    int nxt;
    if (!rst) begin
      t = 0; m_full = 0; m_buf = '0; m_frame = '0; m_under = 0; m_valid = 1;
    end else if (m_valid) begin
      accept_now = sample_valid && !m_full;
      nxt = t + 1;
      load_now = (nxt % (2 * CLK_DIV) == 0) && ((nxt / (2 * CLK_DIV)) % (2 * SLOT_W) == 1);
      m_under = 0;
      if (load_now) begin
        if (m_full) begin
          m_frame = m_buf;
          m_full  = 0;
        end else begin
          m_frame = '0;
          m_under = 1;
        end
      end
      if (accept_now) begin
        m_buf  = sample_in;
        m_full = 1;
      end
      t = nxt;
    end
  end

  always @(negedge clk) begin
    int nf, bc, q;
    logic e_sd;
    if (m_valid) begin
      nf = t / (2 * CLK_DIV);
      bc = nf % (2 * SLOT_W);
      q  = ((bc + 2 * SLOT_W - 1) % (2 * SLOT_W)) % SLOT_W;
      e_sd = (q < SAMPLE_W) ? m_frame[SAMPLE_W-1-q] : 1'b0;
      checkOutput("sclk", i2s_sclk, (t / CLK_DIV) % 2);
      checkOutput("ws", i2s_ws, (bc >= SLOT_W) ? 1 : 0);
      checkOutput("sd", i2s_sd, e_sd);
      checkOutput("underrun", underrun, m_under);
      checkOutput("ready", sample_ready, !m_full);
    end
  end

  task automatic doReset(input int n);
    rst = 1'b0;
    applyStimulus(1'b0, '0);
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitCycle(input int target);
    for (int c = 0; c < 5000 && t < target; c++) @(negedge clk);
    if (t < target) checkOutput("wait_timeout", t, target);
  endtask

  // Collect 32 consecutive i2s_sclk rises after skipping `skip` rises
  task automatic captureFrame(input int skip, output logic [31:0] sd_word,
                              output logic [31:0] ws_word, output int under_cnt);
    int got = 0;
    int seen = 0;
    logic prev;
    sd_word = '0; ws_word = '0; under_cnt = 0;
    prev = i2s_sclk;
    for (int c = 0; c < 400 && got < 32; c++) begin
      @(negedge clk);
      if (i2s_sclk && !prev) begin
        if (seen >= skip) begin
          sd_word = {sd_word[30:0], i2s_sd};
          ws_word = {ws_word[30:0], i2s_ws};
          got++;
        end
        seen++;
      end
      if (seen > skip && underrun) under_cnt++;
      prev = i2s_sclk;
    end
    if (got < 32) checkOutput("capture_timeout", got, 32);
  endtask

  initial begin
    logic [31:0] sdw, wsw;
    int ucnt;
    int u_t[$];
    int ws_fall[$];
    logic ws_prev;
    int first_rise, first_under;
    logic [7:0] vals [2];
    int idx;
    bit taken;
    int rst_at;

    // Reset held with valid high: nothing may be accepted
    rst = 1'b0;
    applyStimulus(1'b1, 8'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_sclk", i2s_sclk, 0);
      checkOutput("rst_ws", i2s_ws, 0);
      checkOutput("rst_sd", i2s_sd, 0);
      checkOutput("rst_underrun", underrun, 0);
      checkOutput("rst_ready", sample_ready, 1);
    end

    // Single sample A7 in the first released cycle
    rst = 1'b1;
    applyStimulus(1'b1, 8'hA7);
    @(negedge clk);
    checkOutput("a7_accepted", sample_ready, 0);
    applyStimulus(1'b0, '0);
    captureFrame(0, sdw, wsw, ucnt);
    checkOutput("a7_frame0_sd", sdw, 32'h53805380);
    checkOutput("a7_frame0_ws", wsw, 32'h0000FFFF);
    checkOutput("a7_frame0_underrun", ucnt, 0);
    captureFrame(0, sdw, wsw, ucnt);
    checkOutput("idle_frame1_sd", sdw, 32'h0);
    checkOutput("idle_frame1_ws", wsw, 32'h0000FFFF);
    checkOutput("idle_frame1_underrun", ucnt, 1);

    // Underrun and word-select periodicity
    ws_prev = i2s_ws;
    for (int c = 0; c < 400 && u_t.size() < 2; c++) begin
      @(negedge clk);
      if (underrun) u_t.push_back(t);
      if (ws_prev && !i2s_ws) ws_fall.push_back(t);
      ws_prev = i2s_ws;
    end
    checkOutput("underrun_seen", u_t.size(), 2);
    if (u_t.size() == 2) begin
      checkOutput("underrun_first_t", u_t[0], 260);
      checkOutput("underrun_period", u_t[1] - u_t[0], 128);
    end
    checkOutput("ws_falls_seen", ws_fall.size(), 2);
    if (ws_fall.size() == 2) checkOutput("ws_period", ws_fall[1] - ws_fall[0], 128);

    // Mid-frame reset at bit_cnt 5 with a sample sitting in the buffer
    waitCycle(400);
    applyStimulus(1'b1, 8'h99);
    @(negedge clk);
    checkOutput("mid_buffer_full", sample_ready, 0);
    applyStimulus(1'b0, '0);
    waitCycle(404);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_sclk", i2s_sclk, 0);
    checkOutput("mid_rst_ws", i2s_ws, 0);
    checkOutput("mid_rst_sd", i2s_sd, 0);
    checkOutput("mid_rst_ready", sample_ready, 1);
    rst = 1'b1;
    first_rise = -1;
    first_under = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (first_rise < 0 && i2s_sclk) first_rise = t;
      if (first_under < 0 && underrun) first_under = t;
    end
    checkOutput("mid_first_rise", first_rise, 2);
    checkOutput("mid_first_fall_load", first_under, 4);

    // Back-to-back D6 then 3C with valid held
    doReset(2);
    vals[0] = 8'hD6;
    vals[1] = 8'h3C;
    idx = 0;
    applyStimulus(1'b1, vals[0]);
    taken = sample_ready;
    for (int c = 0; c < 300 && idx < 2; c++) begin
      @(negedge clk);
      if (t == 4) checkOutput("b2b_ready_rise", sample_ready, 1);
      if (t == 5) checkOutput("b2b_ready_drop", sample_ready, 0);
      if (taken) begin
        idx++;
        if (idx < 2) applyStimulus(1'b1, vals[idx]);
        else applyStimulus(1'b0, '0);
      end
      taken = sample_ready && sample_valid;
    end
    captureFrame(31, sdw, wsw, ucnt);
    checkOutput("b2b_frame1_sd", sdw, exp_word(8'h3C));
    checkOutput("b2b_frame1_underrun", ucnt, 0);
    checkOutput("b2b_ready_after", sample_ready, 1);

    // Sample offered in the cycle whose edge performs the first frame load
    doReset(2);
    waitCycle(3);
    checkOutput("sim_ready_before", sample_ready, 1);
    applyStimulus(1'b1, 8'h5A);
    @(negedge clk);
    checkOutput("sim_underrun", underrun, 1);
    checkOutput("sim_held", sample_ready, 0);
    applyStimulus(1'b0, '0);
    captureFrame(31, sdw, wsw, ucnt);
    checkOutput("sim_frame1_sd", sdw, exp_word(8'h5A));
    checkOutput("sim_frame1_underrun", ucnt, 0);

    // Random traffic with one random reset pulse
    doReset(2);
    rst_at = $urandom_range(300, 1200);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = (c == rst_at) ? 1'b0 : 1'b1;
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
    end

    applyStimulus(1'b0, '0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
